// File: rtl/stepper_axis_if.sv
// stepper_axis_if: host-side bus for one stepper axis.
//   Inputs to the axis: steps_in, half_period, enable_in, endstop_min/max, start, abort,
//   pos_load, pos_value. Outputs from the axis: step, enable_n, dir, busy, done,
//   stop_reason, remaining, position.
//   master = host/bridge side, slave = stepper_axis side.
interface stepper_axis_if #(
   parameter int STEP_W  = 32,
   parameter int SPEED_W = 32,
   parameter int POS_W   = 32
);
   logic signed [STEP_W-1:0]  steps_in;
   logic        [SPEED_W-1:0] half_period;
   logic                      enable_in;
   logic                      endstop_min;
   logic                      endstop_max;
   logic                      start;
   logic                      abort;
   logic                      pos_load;
   logic signed [POS_W-1:0]   pos_value;
   logic                      step;
   logic                      enable_n;
   logic                      dir;
   logic                      busy;
   logic                      done;
   logic        [1:0]         stop_reason;
   logic signed [STEP_W-1:0]  remaining;
   logic signed [POS_W-1:0]   position;
   modport master (
      output steps_in, half_period, enable_in, endstop_min, endstop_max, start, abort,
             pos_load, pos_value,
      input  step, enable_n, dir, busy, done, stop_reason, remaining, position
   );
   modport slave (
      input  steps_in, half_period, enable_in, endstop_min, endstop_max, start, abort,
             pos_load, pos_value,
      output step, enable_n, dir, busy, done, stop_reason, remaining, position
   );
endinterface

// File: rtl/stepper_axis.sv
// stepper_axis: single-axis step/dir pulse generator with endstops, abort and position.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : stepper_axis_if.slave carrying move request, limits and status
module stepper_axis #(
   parameter int STEP_W    = 32,
   parameter int SPEED_W   = 32,
   parameter int POS_W     = 32,
   parameter int DIR_SETUP = 4
) (
   input logic           clk,
   input logic           reset,
   stepper_axis_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;
   localparam logic [SPEED_W-1:0] SETUP_LD = SPEED_W'(DIR_SETUP > 0 ? DIR_SETUP - 1 : 0);
   state_t                    state_q, state_d;
   logic        [SPEED_W-1:0] cnt_q, cnt_d, hp_q, hp_d, hp_in;
   logic        [STEP_W-1:0]  mag_q, mag_d, mag_in;
   logic signed [POS_W-1:0]   pos_q, pos_d;
   logic                      dir_q, dir_d, done_q, done_d;
   logic        [1:0]         reason_q, reason_d, min_q, max_q;
   logic                      blk, blk_in, stop, tz;
   assign hp_in  = bus.half_period == '0 ? SPEED_W'(1) : bus.half_period;
   assign mag_in = bus.steps_in[STEP_W-1] ? -bus.steps_in : bus.steps_in;
   // the blocking switch depends on the direction of travel: the new move's sign when idle
   assign blk_in = bus.steps_in[STEP_W-1] ? min_q[1] : max_q[1];
   assign blk    = dir_q ? min_q[1] : max_q[1];
   assign stop   = bus.abort | blk;
   assign tz     = cnt_q == '0;
   assign bus.step        = state_q == HIGH;
   assign bus.enable_n    = ~bus.enable_in;
   assign bus.dir         = dir_q;
   assign bus.busy        = state_q != IDLE;
   assign bus.done        = done_q;
   assign bus.stop_reason = reason_q;
   assign bus.remaining   = dir_q ? -mag_q : mag_q;
   assign bus.position    = pos_q;
   always_ff @(posedge clk) begin
      min_q <= {min_q[0], bus.endstop_min};
      max_q <= {max_q[0], bus.endstop_max};
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hp_q     <= '0;
         mag_q    <= '0;
         pos_q    <= '0;
         dir_q    <= 1'b0;
         done_q   <= 1'b0;
         reason_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hp_q     <= hp_d;
         mag_q    <= mag_d;
         pos_q    <= pos_d;
         dir_q    <= dir_d;
         done_q   <= done_d;
         reason_q <= reason_d;
      end
   end
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q - SPEED_W'(1);
      hp_d     = hp_q;
      mag_d    = mag_q;
      pos_d    = pos_q;
      dir_d    = dir_q;
      done_d   = 1'b0;
      reason_d = reason_q;
      case (state_q)
         IDLE: begin
            cnt_d = cnt_q;
            if (bus.pos_load) pos_d = bus.pos_value;
            if (bus.start) begin
               if (bus.steps_in == '0 || blk_in) begin
                  done_d   = 1'b1;
                  reason_d = bus.steps_in == '0 ? 2'd0 : 2'd1;
               end else begin
                  dir_d   = bus.steps_in[STEP_W-1];
                  mag_d   = mag_in;
                  hp_d    = hp_in;
                  state_d = DIR_SETUP > 0 ? SETUP : HIGH;
                  cnt_d   = DIR_SETUP > 0 ? SETUP_LD : hp_in - SPEED_W'(1);
               end
            end
         end
         SETUP: begin
            if (stop) begin
               state_d  = IDLE;
               done_d   = 1'b1;
               reason_d = bus.abort ? 2'd2 : 2'd1;
            end else if (tz) begin
               state_d = HIGH;
               cnt_d   = hp_q - SPEED_W'(1);
            end
         end
         HIGH: begin
            // a step cut short by a stop still completes its falling edge, so it is counted
            if (stop || tz) begin
               mag_d   = mag_q - STEP_W'(1);
               pos_d   = dir_q ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
               state_d = stop ? IDLE : LOW;
               cnt_d   = hp_q - SPEED_W'(1);
            end
            if (stop) begin
               done_d   = 1'b1;
               reason_d = bus.abort ? 2'd2 : 2'd1;
            end
         end
         LOW: begin
            if (stop || (tz && mag_q == '0)) begin
               state_d  = IDLE;
               done_d   = 1'b1;
               reason_d = bus.abort ? 2'd2 : stop ? 2'd1 : 2'd0;
            end else if (tz) begin
               state_d = HIGH;
               cnt_d   = hp_q - SPEED_W'(1);
            end
         end
      endcase
   end
endmodule

// File: tb/tb_stepper_axis.sv
// tb_stepper_axis: randomized and directed checks of stepper_axis against a move-level model.
module tb_stepper_axis;
   localparam int SW = 8;
   localparam int VW = 8;
   localparam int PW = 16;
   localparam int DS = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   stepper_axis_if #(.STEP_W(SW), .SPEED_W(VW), .POS_W(PW)) bus ();
   stepper_axis #(.STEP_W(SW), .SPEED_W(VW), .POS_W(PW), .DIR_SETUP(DS)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   int errors = 0;
   int checks = 0;
   int cyc = 0, rises = 0, falls = 0, dones = 0, busy_cyc = 0, first_delay = -1;
   int hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0, hi_run = 0, lo_run = 0;
   bit lo_valid = 0, prev_step = 0, prev_busy = 0, dir_at_rise = 0;
   logic [SW-1:0] rem_at_rise = '0;
   logic signed [PW-1:0] pos_m = '0;

   // pulse-shape monitor: counts edges and run lengths as seen at each falling clock edge
   initial forever begin
      @(negedge clk);
      cyc++;
      if (bus.start && !bus.busy) begin
         first_delay = -1; hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0; lo_valid = 0;
      end
      if (bus.busy && !prev_busy) busy_cyc = cyc;
      if (bus.step && !prev_step) begin
         rises++;
         hi_run = 1;
         if (first_delay < 0) begin
            first_delay = cyc - busy_cyc; dir_at_rise = bus.dir; rem_at_rise = bus.remaining;
         end
         if (lo_valid) begin
            lo_min = lo_run < lo_min ? lo_run : lo_min;
            lo_max = lo_run > lo_max ? lo_run : lo_max;
         end
      end else if (bus.step) hi_run++;
      else if (prev_step) begin
         falls++;
         hi_min = hi_run < hi_min ? hi_run : hi_min;
         hi_max = hi_run > hi_max ? hi_run : hi_max;
         lo_run = 1;
         lo_valid = 1;
      end else lo_run++;
      if (bus.done) dones++;
      prev_step = bus.step;
      prev_busy = bus.busy;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drv();
      @(posedge clk);
      #1;
   endtask

   task automatic run_move(input int s, input int hp, input bit ld, input int lv, output bit to);
      int d0;
      d0 = dones;
      drv();
      bus.steps_in = SW'(s); bus.half_period = hp[VW-1:0]; bus.start = 1'b1;
      bus.pos_load = ld; bus.pos_value = PW'(lv);
      drv();
      bus.start = 1'b0; bus.pos_load = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 600; i++) begin
         tick();
         if (dones != d0) begin to = 1'b0; break; end
      end
      tick(); tick();
   endtask

   task automatic test_reset();
      bus.steps_in = '0; bus.half_period = '0; bus.enable_in = 1'b1; bus.endstop_min = 1'b0;
      bus.endstop_max = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.pos_load = 1'b0; bus.pos_value = '0;
      reset = 1'b1;
      repeat (3) drv();
      tick();
      checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL reset_step got=%0d want=0", bus.step); end
      checks++; if (bus.dir !== 1'b0) begin errors++; $display("FAIL reset_dir got=%0d want=0", bus.dir); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0d want=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0d want=0", bus.done); end
      checks++; if (bus.stop_reason !== 2'd0) begin errors++; $display("FAIL reset_reason got=%0d want=0", bus.stop_reason); end
      checks++; if (bus.remaining !== '0) begin errors++; $display("FAIL reset_remaining got=%0d want=0", bus.remaining); end
      checks++; if (bus.position !== '0) begin errors++; $display("FAIL reset_position got=%0d want=0", bus.position); end
      checks++; if (bus.enable_n !== 1'b0) begin errors++; $display("FAIL enable_n_hi got=%0d want=0", bus.enable_n); end
      bus.enable_in = 1'b0;
      #1;
      checks++; if (bus.enable_n !== 1'b1) begin errors++; $display("FAIL enable_n_lo got=%0d want=1", bus.enable_n); end
      drv();
      reset = 1'b0;
      bus.enable_in = 1'b1;
      pos_m = '0;
   endtask

   task automatic test_moves();
      int ts[$], th[$], tl[$], tv[$];
      int r0, d0, n, h, s;
      bit to;
      ts = '{5, -3, 0}; th = '{3, 1, 2}; tl = '{0, 1, 0}; tv = '{0, 100, 0};
      for (int i = 0; i < 10; i++) begin
         ts.push_back(int'($urandom_range(0, 24)) - 12);
         th.push_back(int'($urandom_range(0, 4)));
         tl.push_back(int'($urandom_range(0, 3) == 0));
         tv.push_back(int'($urandom_range(0, 2000)) - 1000);
      end
      foreach (ts[k]) begin
         s = ts[k];
         n = s < 0 ? -s : s;
         h = th[k] == 0 ? 1 : th[k];
         r0 = rises; d0 = dones;
         run_move(s, th[k], tl[k][0], tv[k], to);
         if (tl[k] != 0) pos_m = PW'(tv[k]);
         pos_m = pos_m + PW'(s);
         checks++; if (to !== 1'b0) begin errors++; $display("FAIL move%0d_timeout got=1 want=0", k); end
         checks++; if (rises - r0 != n) begin errors++; $display("FAIL move%0d_pulses got=%0d want=%0d", k, rises - r0, n); end
         checks++; if (dones - d0 != 1) begin errors++; $display("FAIL move%0d_dones got=%0d want=1", k, dones - d0); end
         checks++; if (bus.stop_reason !== 2'd0) begin errors++; $display("FAIL move%0d_reason got=%0d want=0", k, bus.stop_reason); end
         checks++; if (bus.position !== pos_m) begin errors++; $display("FAIL move%0d_position got=%0d want=%0d", k, bus.position, pos_m); end
         checks++; if (bus.remaining !== '0) begin errors++; $display("FAIL move%0d_remaining got=%0d want=0", k, bus.remaining); end
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL move%0d_busy got=1 want=0", k); end
         if (n > 0) begin
            checks++; if (first_delay != DS) begin errors++; $display("FAIL move%0d_first_rise got=%0d want=%0d", k, first_delay, DS); end
            checks++; if (hi_min != h || hi_max != h) begin errors++; $display("FAIL move%0d_high got=%0d..%0d want=%0d", k, hi_min, hi_max, h); end
            checks++; if (dir_at_rise != (s < 0)) begin errors++; $display("FAIL move%0d_dir got=%0d want=%0d", k, dir_at_rise, s < 0); end
            checks++; if (rem_at_rise !== SW'(s)) begin errors++; $display("FAIL move%0d_rem_start got=%0d want=%0d", k, rem_at_rise, s); end
         end
         if (n > 1) begin
            checks++; if (lo_min != h || lo_max != h) begin errors++; $display("FAIL move%0d_low got=%0d..%0d want=%0d", k, lo_min, lo_max, h); end
         end
      end
   endtask

   task automatic test_endstop_min();
      int r0, f0, d0, k;
      bit to;
      logic signed [PW-1:0] pos0;
      pos0 = pos_m; r0 = rises; f0 = falls; d0 = dones;
      drv();
      bus.steps_in = SW'(-10); bus.half_period = 8'd2; bus.start = 1'b1;
      drv();
      bus.start = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (rises - r0 >= 4) break;
      end
      bus.endstop_min = 1'b1;
      to = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (dones != d0) begin to = 1'b0; break; end
      end
      tick();
      k = rises - r0;
      pos_m = pos0 - PW'(k);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL esmin_timeout got=1 want=0"); end
      checks++; if (bus.stop_reason !== 2'd1) begin errors++; $display("FAIL esmin_reason got=%0d want=1", bus.stop_reason); end
      checks++; if (bus.step !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL esmin_idle got=%0d%0d want=00", bus.step, bus.busy); end
      checks++; if (k < 4 || k > 5) begin errors++; $display("FAIL esmin_pulses got=%0d want=4..5", k); end
      checks++; if (falls - f0 != k) begin errors++; $display("FAIL esmin_falls got=%0d want=%0d", falls - f0, k); end
      checks++; if (bus.position !== pos_m) begin errors++; $display("FAIL esmin_position got=%0d want=%0d", bus.position, pos_m); end
      checks++; if (bus.remaining !== SW'(k - 10)) begin errors++; $display("FAIL esmin_remaining got=%0d want=%0d", bus.remaining, k - 10); end
      bus.endstop_min = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_endstop_max();
      int r0, d0;
      bit to;
      bus.endstop_max = 1'b1;
      repeat (3) tick();
      r0 = rises;
      run_move(-2, 1, 1'b0, 0, to);
      pos_m = pos_m - PW'(2);
      checks++; if (to !== 1'b0 || rises - r0 != 2) begin errors++; $display("FAIL esmax_back got=%0d pulses want=2", rises - r0); end
      checks++; if (bus.stop_reason !== 2'd0) begin errors++; $display("FAIL esmax_back_reason got=%0d want=0", bus.stop_reason); end
      checks++; if (bus.position !== pos_m) begin errors++; $display("FAIL esmax_back_pos got=%0d want=%0d", bus.position, pos_m); end
      r0 = rises; d0 = dones;
      run_move(2, 1, 1'b0, 0, to);
      checks++; if (to !== 1'b0 || dones - d0 != 1) begin errors++; $display("FAIL esmax_reject_done got=%0d want=1", dones - d0); end
      checks++; if (bus.stop_reason !== 2'd1) begin errors++; $display("FAIL esmax_reject_reason got=%0d want=1", bus.stop_reason); end
      checks++; if (rises != r0) begin errors++; $display("FAIL esmax_reject_pulses got=%0d want=0", rises - r0); end
      checks++; if (bus.position !== pos_m || bus.dir !== 1'b1) begin errors++; $display("FAIL esmax_reject_state got=%0d/%0d want=%0d/1", bus.position, bus.dir, pos_m); end
      bus.endstop_max = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_abort();
      int r0, f0, d0;
      bit to;
      r0 = rises; f0 = falls; d0 = dones;
      drv();
      bus.steps_in = SW'(10); bus.half_period = 8'd6; bus.start = 1'b1;
      drv();
      bus.start = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (rises - r0 >= 2 && !bus.step) break;
      end
      bus.endstop_max = 1'b1;
      tick(); tick();
      bus.abort = 1'b1;
      to = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (dones != d0) begin to = 1'b0; break; end
      end
      bus.abort = 1'b0; bus.endstop_max = 1'b0;
      pos_m = pos_m + PW'(2);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL abort_timeout got=1 want=0"); end
      checks++; if (bus.stop_reason !== 2'd2) begin errors++; $display("FAIL abort_reason got=%0d want=2", bus.stop_reason); end
      checks++; if (rises - r0 != 2 || falls - f0 != 2) begin errors++; $display("FAIL abort_pulses got=%0d/%0d want=2/2", rises - r0, falls - f0); end
      checks++; if (bus.position !== pos_m) begin errors++; $display("FAIL abort_position got=%0d want=%0d", bus.position, pos_m); end
      checks++; if (bus.remaining !== SW'(8)) begin errors++; $display("FAIL abort_remaining got=%0d want=8", bus.remaining); end
      repeat (3) tick();
      d0 = dones;
      drv(); bus.abort = 1'b1;
      drv(); bus.abort = 1'b0;
      tick(); tick();
      checks++; if (dones != d0 || bus.stop_reason !== 2'd2) begin errors++; $display("FAIL idle_abort got=%0d dones reason %0d want=0 dones reason 2", dones - d0, bus.stop_reason); end
   endtask

   task automatic test_back_to_back();
      int r0, d0;
      bit to;
      r0 = rises; d0 = dones;
      drv();
      bus.steps_in = SW'(3); bus.half_period = 8'd2; bus.start = 1'b1;
      drv();
      bus.start = 1'b0;
      repeat (3) tick();
      drv();
      bus.steps_in = SW'(7); bus.start = 1'b1; bus.pos_load = 1'b1; bus.pos_value = PW'(555);
      drv();
      bus.start = 1'b0; bus.pos_load = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (dones != d0) begin to = 1'b0; break; end
      end
      repeat (30) tick();
      pos_m = pos_m + PW'(3);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL busy_start_timeout got=1 want=0"); end
      checks++; if (rises - r0 != 3 || dones - d0 != 1) begin errors++; $display("FAIL busy_start_ignored got=%0d pulses %0d dones want=3 1", rises - r0, dones - d0); end
      checks++; if (bus.position !== pos_m) begin errors++; $display("FAIL busy_load_ignored got=%0d want=%0d", bus.position, pos_m); end
   endtask

   task automatic test_reset_mid();
      int r0, d0;
      r0 = rises; d0 = dones;
      drv();
      bus.steps_in = SW'(4); bus.half_period = 8'd4; bus.start = 1'b1;
      drv();
      bus.start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (rises != r0) break;
      end
      checks++; if (bus.step !== 1'b1) begin errors++; $display("FAIL rstmid_pre_step got=%0d want=1", bus.step); end
      reset = 1'b1;
      tick();
      checks++; if (bus.step !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=%0d%0d want=00", bus.step, bus.busy); end
      checks++; if (bus.position !== '0) begin errors++; $display("FAIL rstmid_position got=%0d want=0", bus.position); end
      drv();
      reset = 1'b0;
      tick(); tick();
      checks++; if (dones != d0) begin errors++; $display("FAIL rstmid_done got=%0d want=0", dones - d0); end
      pos_m = '0;
   endtask

   task automatic test_min_move();
      int r0;
      bit to;
      r0 = rises;
      run_move(-(1 << (SW - 1)), 1, 1'b0, 0, to);
      pos_m = pos_m - PW'(1 << (SW - 1));
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL minmove_timeout got=1 want=0"); end
      checks++; if (rises - r0 != (1 << (SW - 1))) begin errors++; $display("FAIL minmove_pulses got=%0d want=%0d", rises - r0, 1 << (SW - 1)); end
      checks++; if (rem_at_rise !== 8'h80) begin errors++; $display("FAIL minmove_rem_start got=%0h want=80", rem_at_rise); end
      checks++; if (bus.remaining !== '0 || bus.dir !== 1'b1) begin errors++; $display("FAIL minmove_end got=%0d/%0d want=0/1", bus.remaining, bus.dir); end
      checks++; if (bus.position !== pos_m) begin errors++; $display("FAIL minmove_position got=%0d want=%0d", bus.position, pos_m); end
   endtask

   initial begin
      test_reset();
      test_moves();
      test_endstop_min();
      test_endstop_max();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      test_min_move();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
